// File: rtl/temp_report_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// temp_report_pkg : shared types, ASCII constants and frame-layout helpers
// Revision: 1.0
//------------------------------------------------------------------------------
package temp_report_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FRAME_MAX_LEN = 14;
  localparam int BCD_DIGITS    = 5;

  localparam logic [7:0] ASCII_T     = 8'h74;
  localparam logic [7:0] ASCII_E     = 8'h65;
  localparam logic [7:0] ASCII_M     = 8'h6D;
  localparam logic [7:0] ASCII_P     = 8'h70;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [3:0] IDX_LF = 4'(FRAME_MAX_LEN - 1);

  typedef logic [BCD_DIGITS-1:0][3:0] bcd_t;

  // Frame slots 0..13: "temp:" '-' d4 d3 d2 '.' d1 d0 CR LF; absent slots are jumped over.
  function automatic logic [3:0] next_idx(input logic [3:0] idx, input logic sign,
                                          input bcd_t d);
    logic d4_nz;
    logic d43_nz;
    logic [3:0] nxt;
    d4_nz  = (d[4] != 4'd0);
    d43_nz = d4_nz || (d[3] != 4'd0);
    case (idx)
      4'd4:    nxt = sign ? 4'd5 : (d4_nz ? 4'd6 : (d43_nz ? 4'd7 : 4'd8));
      4'd5:    nxt = d4_nz ? 4'd6 : (d43_nz ? 4'd7 : 4'd8);
      default: nxt = idx + 4'd1;
    endcase
    return nxt;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input bcd_t d);
    logic [7:0] b;
    case (idx)
      4'd0:    b = ASCII_T;
      4'd1:    b = ASCII_E;
      4'd2:    b = ASCII_M;
      4'd3:    b = ASCII_P;
      4'd4:    b = ASCII_COLON;
      4'd5:    b = ASCII_MINUS;
      4'd6:    b = ASCII_0 + {4'h0, d[4]};
      4'd7:    b = ASCII_0 + {4'h0, d[3]};
      4'd8:    b = ASCII_0 + {4'h0, d[2]};
      4'd9:    b = ASCII_DOT;
      4'd10:   b = ASCII_0 + {4'h0, d[1]};
      4'd11:   b = ASCII_0 + {4'h0, d[0]};
      4'd12:   b = ASCII_CR;
      4'd13:   b = ASCII_LF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/temp_uart_reporter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// temp_uart_reporter_if : tx FIFO write port (reporter = master, FIFO = slave)
// Revision: 1.0
//------------------------------------------------------------------------------
interface temp_uart_reporter_if;
  logic       fifo_full;
  logic       fifo_wrreq;
  logic [7:0] fifo_data;

  modport master (input fifo_full, output fifo_wrreq, output fifo_data);
  modport slave  (output fifo_full, input fifo_wrreq, input fifo_data);
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// bin2bcd_seq : iterative double-dabble, one shift per cycle, DATA_W cycles
// Revision: 1.0
//------------------------------------------------------------------------------
module bin2bcd_seq
  import temp_report_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_bin,
  output logic              o_done,
  output bcd_t              o_digits
);

  localparam int SHIFT_W = BCD_DIGITS * 4 + DATA_W;
  localparam int CNT_W   = $clog2(DATA_W);

  logic [SHIFT_W-1:0] r_shift;
  logic [SHIFT_W-1:0] w_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_active;
  logic               r_done;
  logic               w_unused_msb;

  always_comb begin
    w_adj = r_shift;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (r_shift[DATA_W + 4*k +: 4] >= 4'd5)
        w_adj[DATA_W + 4*k +: 4] = r_shift[DATA_W + 4*k +: 4] + 4'd3;
    end
  end

  // The top digit never exceeds 1 for a 14-bit input, so its shifted-out MSB is always 0.
  assign w_unused_msb = w_adj[SHIFT_W-1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_shift  <= {{(BCD_DIGITS*4){1'b0}}, i_bin};
        r_cnt    <= '0;
        r_active <= 1'b1;
      end else if (r_active) begin
        r_shift <= {w_adj[SHIFT_W-2:0], 1'b0};
        r_cnt   <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_done   = r_done;
  assign o_digits = r_shift[SHIFT_W-1:DATA_W];

endmodule
`default_nettype wire

// File: rtl/temp_uart_reporter.sv
`default_nettype none
//------------------------------------------------------------------------------
// temp_uart_reporter : periodic temperature snapshot, BCD convert, ASCII frame to FIFO
// Revision: 1.0
//------------------------------------------------------------------------------
module temp_uart_reporter
  import temp_report_pkg::*;
#(
  parameter int PERIOD_CYCLES = 50_000_000,
  parameter int DATA_W        = 14
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  enable,
  input  logic [DATA_W-1:0]     temp_data,
  input  logic                  temp_sign,
  temp_uart_reporter_if.master  fifo,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            overrun_cnt
);

  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic             w_tick;
  logic             w_start;
  logic             w_wr;
  logic             w_bcd_done;
  bcd_t             w_digits;
  logic [3:0]       r_idx;
  logic             r_sign;
  logic [7:0]       r_overrun;

  assign w_tick  = enable && (r_count == CNT_W'(PERIOD_CYCLES - 1));
  assign w_start = (r_state == IDLE) && w_tick;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  r_count <= '0;
    else if (!enable || w_tick) r_count <= '0;
    else             r_count <= r_count + CNT_W'(1);
  end

  // The converter's shift register is the magnitude snapshot; it is held until the next start.
  bin2bcd_seq #(.DATA_W(DATA_W)) u_bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_start   (w_start),
    .i_bin     (temp_data),
    .o_done    (w_bcd_done),
    .o_digits  (w_digits)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    case (r_state)
      IDLE: if (w_tick) w_state_nxt = CONV;
      CONV: if (w_bcd_done) w_state_nxt = SEND;
      SEND: begin
        w_wr = !fifo.fifo_full;
        if (w_wr && (r_idx == IDX_LF)) w_state_nxt = DONE;
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idx     <= '0;
      r_sign    <= 1'b0;
      r_overrun <= '0;
    end else begin
      if (w_start) begin
        r_idx  <= '0;
        r_sign <= temp_sign;
      end else if (w_wr) begin
        r_idx <= next_idx(r_idx, r_sign, w_digits);
      end
      if (w_tick && (r_state != IDLE) && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;
    end
  end

  assign fifo.fifo_wrreq = w_wr;
  assign fifo.fifo_data  = (r_state == SEND) ? frame_byte(r_idx, w_digits) : 8'h00;
  assign busy            = (r_state == CONV) || (r_state == SEND);
  assign frame_done      = (r_state == DONE);
  assign overrun_cnt     = r_overrun;

endmodule
`default_nettype wire
